// File: rtl/spgd_pkg.sv
// Shared types and defaults for the SPGD dither driver.
// The optional MEAS watchdog is enabled with the SPGD_DITHER_TIMEOUT_EN macro.
package spgd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY_P  = 3'd1,
    SETTLE_P = 3'd2,
    MEAS_P   = 3'd3,
    APPLY_N  = 3'd4,
    SETTLE_N = 3'd5,
    MEAS_N   = 3'd6,
    REPORT   = 3'd7
  } spgd_state_e;

  localparam int DAC_WIDTH_DEF      = 14;
  localparam int ADC_WIDTH_DEF      = 12;
  localparam int SETTLE_CYCLES_DEF  = 16;
  localparam int TIMEOUT_CYCLES_DEF = 65536;

  // Two's-complement code range for the default DAC width.
  localparam int DAC_MAX = (1 << (DAC_WIDTH_DEF - 1)) - 1;
  localparam int DAC_MIN = -(1 << (DAC_WIDTH_DEF - 1));

endpackage

// File: rtl/spgd_code_clamp.sv
// Combinational base +/- delta at W+1 bits, saturated back to a W-bit
// two's-complement code, with a flag raised whenever clamping occurred.
module spgd_code_clamp
  import spgd_pkg::*;
#(
  parameter int W = DAC_WIDTH_DEF
) (
  input  logic [W-1:0] base_i,
  input  logic [W-2:0] delta_i,
  input  logic         sub_i,
  output logic [W-1:0] code_o,
  output logic         sat_o
);

  logic [W:0] base_ext;
  logic [W:0] delta_ext;
  logic [W:0] sum;

  always_comb begin
    base_ext  = {base_i[W-1], base_i};
    delta_ext = {2'b00, delta_i};
    sum       = sub_i ? (base_ext - delta_ext) : (base_ext + delta_ext);
    // The wide result leaves the W-bit range exactly when its top two bits differ.
    sat_o     = sum[W] ^ sum[W-1];
    if (!sat_o) begin
      code_o = sum[W-1:0];
    end else if (sum[W]) begin
      code_o = {1'b1, {(W-1){1'b0}}};
    end else begin
      code_o = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/spgd_dither_driver.sv
// Two-sided SPGD dither around a latched base code, measuring the averaged
// metric on each side. Optional MEAS watchdog: SPGD_DITHER_TIMEOUT_EN.
module spgd_dither_driver
  import spgd_pkg::*;
#(
  parameter int DAC_WIDTH      = DAC_WIDTH_DEF,
  parameter int ADC_WIDTH      = ADC_WIDTH_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 ADC_CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic [DAC_WIDTH-1:0] BASE_CODE,
  input  logic [DAC_WIDTH-2:0] DELTA,
  input  logic                 AVG_DONE,
  input  logic [ADC_WIDTH-1:0] AVG_DATA,
  output logic                 AVG_RST,
  output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
  output logic [ADC_WIDTH:0]   DIFF_OUT,
  output logic                 DIFF_VALID,
  output logic                 SAT_OUT,
  output logic                 BUSY,
  output logic                 TIMEOUT_FLAG,
  output logic [2:0]           STATE_DBG
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  spgd_state_e          state_q, state_d;
  logic [DAC_WIDTH-1:0] base_q, base_d;
  logic [DAC_WIDTH-2:0] delta_q, delta_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0] mp_q, mp_d, mn_q, mn_d;
  logic [ADC_WIDTH:0]   diff_q, diff_d;
  logic                 sat_q, sat_d, sat_out_q, sat_out_d;
  logic                 dv_q, dv_d, to_q, to_d;
  logic                 start, abort;

  logic [DAC_WIDTH-1:0] code_p, code_n;
  logic                 sat_p, sat_n;

  spgd_code_clamp #(.W(DAC_WIDTH)) u_clamp_p (
    .base_i (base_q), .delta_i (delta_q), .sub_i (1'b0), .code_o (code_p), .sat_o (sat_p)
  );

  spgd_code_clamp #(.W(DAC_WIDTH)) u_clamp_n (
    .base_i (base_q), .delta_i (delta_q), .sub_i (1'b1), .code_o (code_n), .sat_o (sat_n)
  );

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      base_q    <= '0;
      delta_q   <= '0;
      dac_q     <= '0;
      cnt_q     <= '0;
      mp_q      <= '0;
      mn_q      <= '0;
      diff_q    <= '0;
      sat_q     <= 1'b0;
      sat_out_q <= 1'b0;
      dv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      delta_q   <= delta_d;
      dac_q     <= dac_d;
      cnt_q     <= cnt_d;
      mp_q      <= mp_d;
      mn_q      <= mn_d;
      diff_q    <= diff_d;
      sat_q     <= sat_d;
      sat_out_q <= sat_out_d;
      dv_q      <= dv_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    delta_d   = delta_q;
    dac_d     = dac_q;
    cnt_d     = cnt_q;
    mp_d      = mp_q;
    mn_d      = mn_q;
    diff_d    = diff_q;
    sat_d     = sat_q;
    sat_out_d = sat_out_q;
    dv_d      = 1'b0;
    to_d      = to_q;
    start     = 1'b0;
    abort     = !ENABLE && (state_q != IDLE) && (state_q != REPORT);

    case (state_q)
      IDLE: start = ENABLE;
      APPLY_P: begin
        dac_d   = code_p;
        sat_d   = sat_q | sat_p;
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE_P;
      end
      APPLY_N: begin
        dac_d   = code_n;
        sat_d   = sat_q | sat_n;
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE_N;
      end
      SETTLE_P, SETTLE_N: begin
        if (cnt_q == '0) begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = (state_q == SETTLE_P) ? MEAS_P : MEAS_N;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEAS_P, MEAS_N: begin
        if (AVG_DONE) begin
          if (state_q == MEAS_P) begin
            mp_d    = AVG_DATA;
            state_d = APPLY_N;
          end else begin
            mn_d    = AVG_DATA;
            state_d = REPORT;
          end
        end
`ifdef SPGD_DITHER_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = IDLE;
          dac_d   = base_q;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      REPORT: begin
        // Zero-extended operands at ADC_WIDTH+1 bits cannot overflow.
        diff_d    = {1'b0, mp_q} - {1'b0, mn_q};
        dv_d      = 1'b1;
        sat_out_d = sat_q;
        dac_d     = base_q;
        if (ENABLE) start = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      base_d  = BASE_CODE;
      delta_d = DELTA;
      sat_d   = 1'b0;
      to_d    = 1'b0;
      state_d = APPLY_P;
    end

    // Abort wins over any capture or watchdog event in the same cycle.
    if (abort) begin
      state_d = IDLE;
      dac_d   = base_q;
      mp_d    = mp_q;
      mn_d    = mn_q;
      sat_d   = sat_q;
      to_d    = to_q;
    end
  end

  assign AVG_RST      = !((state_q == MEAS_P) || (state_q == MEAS_N));
  assign DAC_CODE_OUT = dac_q;
  assign DIFF_OUT     = diff_q;
  assign DIFF_VALID   = dv_q;
  assign SAT_OUT      = sat_out_q;
  assign BUSY         = (state_q != IDLE);
  assign TIMEOUT_FLAG = to_q;
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_spgd_dither_driver.sv
// Scoreboard bench for spgd_dither_driver: directed corner cases plus a random
// back-to-back run; the watchdog check follows SPGD_DITHER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_spgd_dither_driver;
  import spgd_pkg::*;

  localparam int DW = 14;
  localparam int AW = 12;
  localparam int SC = 4;
  localparam int TC = 32;
  localparam int NR = 16;

  // Clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [DW-1:0] base_code = '0;
  logic [DW-2:0] delta = '0;
  logic          avg_done = 1'b0;
  logic [AW-1:0] avg_data = '0;
  logic          avg_rst;
  logic [DW-1:0] dac_code;
  logic [AW:0]   diff_out;
  logic          diff_valid, sat_out, busy, timeout_flag;
  logic [2:0]    state_dbg;

  spgd_dither_driver #(
    .DAC_WIDTH(DW), .ADC_WIDTH(AW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .ADC_CLK(clk), .RST_N(rst_n), .ENABLE(enable), .BASE_CODE(base_code), .DELTA(delta),
    .AVG_DONE(avg_done), .AVG_DATA(avg_data), .AVG_RST(avg_rst), .DAC_CODE_OUT(dac_code),
    .DIFF_OUT(diff_out), .DIFF_VALID(diff_valid), .SAT_OUT(sat_out), .BUSY(busy),
    .TIMEOUT_FLAG(timeout_flag), .STATE_DBG(state_dbg)
  );

  // Handshake: DIFF_VALID is a one-cycle strobe; DIFF_OUT/SAT_OUT/DAC_CODE_OUT are
  // meaningful in that cycle, and every strobe must match one queued expectation.
  typedef struct {
    int diff;
    int sat;
    int base;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int last_diff = 0;
  int last_sat = 0;
  bit prev_dv = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the code range.
  function automatic int clamp_code(input int v);
    if (v > DAC_MAX) return DAC_MAX;
    if (v < DAC_MIN) return DAC_MIN;
    return v;
  endfunction

  function automatic int sdac();
    return int'($signed(dac_code));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dac"}, sdac(), 0);
    check({tag, "_avg_rst"}, int'(avg_rst), 1);
    check({tag, "_diff"}, int'($signed(diff_out)), 0);
    check({tag, "_dv"}, int'(diff_valid), 0);
    check({tag, "_sat"}, int'(sat_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tflag"}, int'(timeout_flag), 0);
  endtask

  // Monitor: pops one expectation per DIFF_VALID strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && diff_valid) begin
      check("dv_single_pulse", int'(prev_dv), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_diff_valid: got strobe with DIFF_OUT=%0d, expected none (t=%0t)",
                 $signed(diff_out), $time);
      end else begin
        e = exp_q.pop_front();
        check("diff_out", int'($signed(diff_out)), e.diff);
        check("sat_out", int'(sat_out), e.sat);
        check("dac_base_after_report", sdac(), e.base);
        last_diff = e.diff;
        last_sat  = e.sat;
      end
    end
    prev_dv = rst_n && diff_valid;
  end

  // Driver tasks (all entered and left on a negedge)
  task automatic start(input int b, input int d);
    base_code = DW'(b);
    delta     = (DW-1)'(d);
    enable    = 1'b1;
  endtask

  task automatic wait_meas(input bit spur, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (spur && i == 1) begin
        avg_done = 1'b1;
        avg_data = AW'(1234);
      end else begin
        avg_done = 1'b0;
      end
      if (!avg_rst) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_meas: got AVG_RST stuck high for 200 cycles, expected a MEAS phase");
    end
  endtask

  task automatic pulse_done(input int m);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    avg_done = 1'b1;
    avg_data = AW'(m);
    @(negedge clk);
    avg_done = 1'b0;
  endtask

  task automatic run_txn(input int b, input int d, input int mp, input int mn, input bit spur,
                         input bit has_next, input int nb, input int nd);
    exp_t e;
    bit got;
    int pc, nc;
    pc = b + d;
    nc = b - d;
    e.base = b;
    e.diff = mp - mn;
    e.sat  = ((clamp_code(pc) != pc) || (clamp_code(nc) != nc)) ? 1 : 0;
    exp_q.push_back(e);
    wait_meas(spur, got);
    if (!got) begin
      void'(exp_q.pop_back());
      enable = 1'b0;
      return;
    end
    check("dac_plus", sdac(), clamp_code(pc));
    pulse_done(mp);
    wait_meas(1'b0, got);
    if (!got) begin
      void'(exp_q.pop_back());
      enable = 1'b0;
      return;
    end
    check("dac_minus", sdac(), clamp_code(nc));
    repeat ($urandom_range(0, 4)) @(negedge clk);
    avg_done = 1'b1;
    avg_data = AW'(mn);
    @(negedge clk);
    avg_done = 1'b0;
    if (has_next) start(nb, nd);
    else          enable = 1'b0;
  endtask

  int rb[NR];
  int rd[NR];

  initial begin
    bit got;
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dither: 120, 80, then back to 100; diff +50
    start(100, 20);
    run_txn(100, 20, 900, 850, 1'b0, 1'b0, 0, 0);
    @(negedge clk);

    // Clamp at both rails, then full-scale metric differences, back to back
    start(8180, 50);
    run_txn(8180, 50, 1000, 1000, 1'b0, 1'b1, -8190, 10);
    run_txn(-8190, 10, 0, 4095, 1'b0, 1'b1, 0, 0);
    run_txn(0, 0, 4095, 0, 1'b0, 1'b1, 300, 7);
    // Spurious AVG_DONE during SETTLE_P must not be captured
    run_txn(300, 7, 2222, 111, 1'b1, 1'b0, 0, 0);
    @(negedge clk);

    // Random back-to-back run
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(0, 3) == 0) rb[i] = ($urandom_range(0, 1) != 0) ? 8191 - int'($urandom_range(0, 40))
                                                                          : -8192 + int'($urandom_range(0, 40));
      else rb[i] = int'($urandom_range(0, 16383)) - 8192;
      rd[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 8191));
    end
    start(rb[0], rd[0]);
    for (int i = 0; i < NR; i++) begin
      run_txn(rb[i], rd[i], int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              bit'($urandom_range(0, 1)), (i < NR - 1), (i < NR - 1) ? rb[i+1] : 0,
              (i < NR - 1) ? rd[i+1] : 0);
    end
    @(negedge clk);

    // Abort in SETTLE_N with a coincident AVG_DONE
    start(500, 30);
    wait_meas(1'b0, got);
    pulse_done(777);
    @(negedge clk);
    enable   = 1'b0;
    avg_done = 1'b1;
    avg_data = AW'(1);
    @(negedge clk);
    avg_done = 1'b0;
    check("abort_sn_busy", int'(busy), 0);
    check("abort_sn_avg_rst", int'(avg_rst), 1);
    check("abort_sn_dac", sdac(), 500);
    check("abort_sn_dv", int'(diff_valid), 0);
    check("abort_sn_diff_hold", int'($signed(diff_out)), last_diff);
    check("abort_sn_sat_hold", int'(sat_out), last_sat);
    repeat (3) @(negedge clk);

    // Abort in MEAS_N together with AVG_DONE: no report may follow
    start(-300, 40);
    wait_meas(1'b0, got);
    pulse_done(100);
    wait_meas(1'b0, got);
    enable   = 1'b0;
    avg_done = 1'b1;
    avg_data = AW'(4000);
    @(negedge clk);
    avg_done = 1'b0;
    check("abort_mn_busy", int'(busy), 0);
    check("abort_mn_dac", sdac(), -300);
    repeat (3) @(negedge clk);

    // Normal transaction after aborts
    start(-1234, 321);
    run_txn(-1234, 321, 17, 4000, 1'b0, 1'b0, 0, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of MEAS_P
    start(1000, 100);
    wait_meas(1'b0, got);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    last_diff = 0;
    last_sat  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Watchdog behaviour while AVG_DONE never arrives
    start(200, 5);
    wait_meas(1'b0, got);
`ifdef SPGD_DITHER_TIMEOUT_EN
    repeat (TC - 1) @(negedge clk);
    check("wd_still_meas", int'(state_dbg), int'(MEAS_P));
    @(negedge clk);
    check("wd_idle", int'(busy), 0);
    check("wd_flag", int'(timeout_flag), 1);
    check("wd_dac", sdac(), 200);
    check("wd_dv", int'(diff_valid), 0);
    enable = 1'b0;
    @(negedge clk);
    start(-50, 5);
    run_txn(-50, 5, 60, 40, 1'b0, 1'b0, 0, 0);
    check("wd_flag_cleared", int'(timeout_flag), 0);
`else
    repeat (1000) @(negedge clk);
    check("no_wd_still_meas", int'(state_dbg), int'(MEAS_P));
    check("no_wd_flag", int'(timeout_flag), 0);
    enable = 1'b0;
    @(negedge clk);
    check("no_wd_abort_idle", int'(busy), 0);
    check("no_wd_abort_dac", sdac(), 200);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
